// File: rtl/seq_divider.sv
// Iterative restoring divider, STEPS_PER_CYCLE quotient bits per clock, RISC-V div/rem semantics.
// Optional build macro DIV_SIGNED_EN enables signed_mode (two's-complement operands and overflow flag).
module seq_divider #(
    parameter int WIDTH           = 16,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int K     = WIDTH / STEPS_PER_CYCLE;
    localparam int CNT_W = $clog2(K + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;

    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH:0]     r_prem;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sp_dbz;
    logic               r_sp_ovf;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_ovf_case;
    logic [WIDTH-1:0]   w_fix_q;
    logic [WIDTH-1:0]   w_fix_r;
    logic [WIDTH:0]     w_prem_nx;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_q_nx;

`ifdef DIV_SIGNED_EN
    logic               r_neg_q;
    logic               r_neg_r;
    logic               w_a_neg;
    logic               w_b_neg;

    function automatic logic [WIDTH-1:0] f_neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    // Magnitudes use WIDTH-bit negation, so MIN stays correct when read as unsigned.
    assign w_a_neg    = signed_mode & dividend[WIDTH-1];
    assign w_b_neg    = signed_mode & divisor[WIDTH-1];
    assign w_a_mag    = f_neg_if(w_a_neg, dividend);
    assign w_b_mag    = f_neg_if(w_b_neg, divisor);
    assign w_ovf_case = signed_mode && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                        && (divisor == {WIDTH{1'b1}});
    assign w_fix_q    = f_neg_if(r_neg_q, r_q);
    assign w_fix_r    = f_neg_if(r_neg_r, r_prem[WIDTH-1:0]);
`else
    logic               w_unused_sm;

    assign w_unused_sm = signed_mode;
    assign w_a_mag     = dividend;
    assign w_b_mag     = divisor;
    assign w_ovf_case  = 1'b0;
    assign w_fix_q     = r_q;
    assign w_fix_r     = r_prem[WIDTH-1:0];
`endif

    // One CALC edge: STEPS_PER_CYCLE shift / trial-subtract / restore iterations.
    always_comb begin
        w_prem_nx = r_prem;
        w_q_nx    = r_q;
        w_diff    = '0;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            w_prem_nx = {w_prem_nx[WIDTH-1:0], w_q_nx[WIDTH-1]};
            w_q_nx    = {w_q_nx[WIDTH-2:0], 1'b0};
            w_diff    = w_prem_nx - {1'b0, r_dvs};
            if (!w_diff[WIDTH]) begin
                w_prem_nx = w_diff;
                w_q_nx[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy   <= 1'b1;
                        r_dbz    <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_q      <= w_a_mag;
                        r_dvs    <= w_b_mag;
                        r_a_raw  <= dividend;
                        r_prem   <= '0;
                        r_cnt    <= CNT_W'(K);
                        r_sp_dbz <= (divisor == '0);
                        r_sp_ovf <= w_ovf_case;
`ifdef DIV_SIGNED_EN
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
`endif
                        if ((divisor == '0) || w_ovf_case) r_state <= S_FIX;
                        else                               r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_prem <= w_prem_nx;
                    r_q    <= w_q_nx;
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (r_sp_dbz) begin
                        r_quot <= {WIDTH{1'b1}};
                        r_rem  <= r_a_raw;
                        r_dbz  <= 1'b1;
                    end else if (r_sp_ovf) begin
                        r_quot <= r_a_raw;
                        r_rem  <= '0;
                        r_ovf  <= 1'b1;
                    end else begin
                        r_quot <= w_fix_q;
                        r_rem  <= w_fix_r;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule
